// File: rtl/encode42_pkg.sv
// encode42_pkg: shared types and widths for the encode42_rr encoder.
//   REQ_W   : number of request lines (4)
//   CODE_W  : width of the encoded index (2)
//   state_e : transfer state, IDLE (nothing pending) or HOLD (valid asserted)
package encode42_pkg;

  localparam int REQ_W  = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/encode42_pick.sv
// encode42_pick: combinational rotating-priority picker.
//   req    in  REQ_W   request lines
//   ptr    in  CODE_W  bit index where the priority search starts
//   winner out CODE_W  first set bit at or above ptr, wrapping past the top
//   any    out 1       at least one request is set
//   multi  out 1       more than one request is set
module encode42_pick
  import encode42_pkg::*;
(
  input  logic [REQ_W-1:0]  req,
  input  logic [CODE_W-1:0] ptr,
  output logic [CODE_W-1:0] winner,
  output logic              any,
  output logic              multi
);

  logic [CODE_W-1:0] idx;

  // Walk offsets from the farthest to the nearest so the lowest offset from
  // ptr is the last assignment and therefore wins. The index add wraps 3->0
  // naturally in CODE_W bits.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = REQ_W - 1; k >= 0; k--) begin
      idx = ptr + CODE_W'(k);
      if (req[idx]) winner = idx;
    end
    any   = |req;
    multi = ($countones(req) > 1);
  end

endmodule

// File: rtl/encode42_rr.sv
// encode42_rr: registered 4-to-2 encoder with a valid/ready output handshake.
//   clk    in  1  rising-edge clock
//   rst_n  in  1  synchronous active-low reset
//   req    in  4  level request lines, bit i encodes to code i
//   ready  in  1  consumer accepts the pending transfer when valid && ready
//   code   out 2  index of the captured winner
//   multi  out 1  more than one request was set at capture
//   valid  out 1  code/multi hold a pending transfer
//   grant  out 4  one-cycle one-hot pulse naming the captured request
// Build option: define ENCODE42_RR_ROUND_ROBIN_EN for round-robin selection;
// without it the lowest set request always wins and no pointer is kept.
module encode42_rr
  import encode42_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REQ_W-1:0]  req,
  input  logic              ready,
  output logic [CODE_W-1:0] code,
  output logic              multi,
  output logic              valid,
  output logic [REQ_W-1:0]  grant
);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              multi_q, multi_d;
  logic [REQ_W-1:0]  grant_q, grant_d;
  logic [CODE_W-1:0] ptr;

  logic [CODE_W-1:0] win;
  logic              any;
  logic              many;
  logic              capture;

  encode42_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (win),
    .any    (any),
    .multi  (many)
  );

  // A new transfer can be loaded when nothing is pending, or when the pending
  // one is being accepted on this same edge.
  assign capture = ((state_q == IDLE) || ready) && any;

`ifdef ENCODE42_RR_ROUND_ROBIN_EN
  logic [CODE_W-1:0] ptr_q, ptr_d;

  assign ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (capture) ptr_d = win + CODE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    multi_d = multi_q;
    grant_d = '0;
    if (capture) begin
      state_d      = HOLD;
      code_d       = win;
      multi_d      = many;
      grant_d[win] = 1'b1;
    end else if ((state_q == HOLD) && ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      multi_q <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      multi_q <= multi_d;
      grant_q <= grant_d;
    end
  end

  assign code  = code_q;
  assign multi = multi_q;
  assign grant = grant_q;
  assign valid = (state_q == HOLD);

endmodule
